// File: rtl/byte_access_unit.sv
// Byte load/store adapter in front of a word-only data memory.
// Word accesses and byte loads pass straight through; byte stores take a two-cycle read-modify-write.
module byte_access_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter int FAULT_CNT_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       Req,
  input  logic                       MemWriteIn,
  input  logic                       ByteAccess,
  input  logic [ADDR_WIDTH-1:0]      Address,
  input  logic [31:0]                WriteData,
  output logic [31:0]                ReadData,
  output logic                       Stall,
  output logic                       Done,
  output logic                       Fault,
  output logic [FAULT_CNT_WIDTH-1:0] FaultCount,
  output logic [ADDR_WIDTH-1:0]      MemAddress,
  output logic [31:0]                MemWriteData,
  output logic                       MemWrite,
  input  logic [31:0]                MemReadData
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  logic [0:0]                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]      addr_reg, addr_next;
  logic [31:0]                merge_reg, merge_next;
  logic [FAULT_CNT_WIDTH-1:0] fault_cnt_reg, fault_cnt_next;

  logic [1:0]  lane;
  logic [7:0]  lane_byte;
  logic [31:0] merged_word;
  logic        misaligned;

  assign lane       = Address[1:0];
  assign lane_byte  = MemReadData[{lane, 3'b000} +: 8];
  assign misaligned = Req && !ByteAccess && (lane != 2'b00);

  // Merged word for a byte store: the addressed lane takes the new byte, others keep memory data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = (lane == 2'(gi)) ? WriteData[7:0] : MemReadData[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    ReadData     = 32'h0;
    Stall        = 1'b0;
    Done         = 1'b0;
    Fault        = 1'b0;
    MemWrite     = 1'b0;
    MemAddress   = Address;
    MemWriteData = WriteData;
    FaultCount   = fault_cnt_reg;
    if (!RESETn) begin
      // Outputs are forced quiet while reset is asserted, aborting any pending write.
      MemAddress   = '0;
      MemWriteData = 32'h0;
    end else if (state_reg == RMW_WR) begin
      MemAddress   = addr_reg;
      MemWriteData = merge_reg;
      MemWrite     = 1'b1;
      Done         = 1'b1;
    end else if (Req) begin
      if (misaligned) begin
        Fault = 1'b1;
        Done  = 1'b1;
      end else if (ByteAccess && MemWriteIn) begin
        Stall = 1'b1;
      end else if (ByteAccess) begin
        ReadData = {24'h0, lane_byte};
        Done     = 1'b1;
      end else if (MemWriteIn) begin
        MemWrite = 1'b1;
        Done     = 1'b1;
      end else begin
        ReadData = MemReadData;
        Done     = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = IDLE;
    addr_next      = addr_reg;
    merge_next     = merge_reg;
    fault_cnt_next = fault_cnt_reg;
    if (state_reg == IDLE) begin
      if (Req && ByteAccess && MemWriteIn) begin
        state_next = RMW_WR;
        addr_next  = {Address[ADDR_WIDTH-1:2], 2'b00};
        merge_next = merged_word;
      end
      if (misaligned && (fault_cnt_reg != '1)) begin
        fault_cnt_next = fault_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      merge_reg     <= 32'h0;
      fault_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      merge_reg     <= merge_next;
      fault_cnt_reg <= fault_cnt_next;
    end
  end

endmodule

// File: tb/tb_byte_access_unit.sv
// Directed bench for byte_access_unit with a small behavioural word memory.
module tb_byte_access_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Req = 1'b0;
  logic        MemWriteIn = 1'b0;
  logic        ByteAccess = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        Fault;
  logic [7:0]  FaultCount;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic [31:0] MemReadData;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'h0;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  byte_access_unit #(.ADDR_WIDTH(32), .FAULT_CNT_WIDTH(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .Req(Req), .MemWriteIn(MemWriteIn),
    .ByteAccess(ByteAccess), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Done(Done), .Fault(Fault),
    .FaultCount(FaultCount), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  assign MemReadData = mem[MemAddress[7:2]];

  always @(posedge CLK) begin
    if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge CLK);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic req, input logic we, input logic bytea,
                       input logic [31:0] addr, input logic [31:0] wd);
    Req = req; MemWriteIn = we; ByteAccess = bytea; Address = addr; WriteData = wd;
  endtask

  task automatic test_reset;
    RESETn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h12345678);
    preload(6'd4, 32'h11223344);
    preload(6'd8, 32'h0);
    preload(6'd12, 32'hCAFEF00D);
    #1;
    total++; if (ReadData !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=%h", ReadData, 32'h0); end
    total++; if ({Stall, Done, Fault, MemWrite} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {Stall, Done, Fault, MemWrite}); end
    total++; if (MemAddress !== 32'h0 || MemWriteData !== 32'h0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", MemAddress, MemWriteData); end
    total++; if (FaultCount !== 8'd0) begin bad++; $display("FAIL reset_faultcount got=%0d exp=0", FaultCount); end
    @(negedge CLK);
    RESETn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h44, 32'h55);
    #1;
    total++; if ({Stall, Done, Fault, MemWrite} !== 4'b0 || ReadData !== 32'h0) begin bad++; $display("FAIL idle_noreq got=%b/%h exp=0000/0", {Stall, Done, Fault, MemWrite}, ReadData); end
    total++; if (MemAddress !== 32'h44 || MemWriteData !== 32'h55) begin bad++; $display("FAIL idle_passthru got=%h/%h exp=44/55", MemAddress, MemWriteData); end
  endtask

  task automatic test_byte_load;
    logic [31:0] exp_rd [0:3];
    exp_rd[0] = 32'h44; exp_rd[1] = 32'h33; exp_rd[2] = 32'h22; exp_rd[3] = 32'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive(1'b1, 1'b0, 1'b1, 32'h10 + 32'(i), 32'h0);
      #1;
      total++; if (ReadData !== exp_rd[i]) begin bad++; $display("FAIL byte_load%0d got=%h exp=%h", i, ReadData, exp_rd[i]); end
      total++; if (Done !== 1'b1 || Stall !== 1'b0) begin bad++; $display("FAIL byte_load%0d_ctrl got=%b%b exp=10", i, Done, Stall); end
    end
  endtask

  task automatic test_byte_store;
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b1, 32'h11, 32'hFFFFFFAB);
    #1;
    total++; if (Stall !== 1'b1 || MemWrite !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL sb_c1 got=%b%b%b exp=100", Stall, MemWrite, Done); end
    total++; if (MemAddress !== 32'h11) begin bad++; $display("FAIL sb_c1_addr got=%h exp=11", MemAddress); end
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 32'h3C, 32'h99999999);
    #1;
    total++; if (MemWrite !== 1'b1 || Done !== 1'b1 || Stall !== 1'b0) begin bad++; $display("FAIL sb_c2_ctrl got=%b%b%b exp=110", MemWrite, Done, Stall); end
    total++; if (MemAddress !== 32'h10) begin bad++; $display("FAIL sb_c2_addr got=%h exp=10", MemAddress); end
    total++; if (MemWriteData !== 32'h1122AB44) begin bad++; $display("FAIL sb_c2_data got=%h exp=1122ab44", MemWriteData); end
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    total++; if (ReadData !== 32'h1122AB44 || Done !== 1'b1) begin bad++; $display("FAIL sb_readback got=%h exp=1122ab44", ReadData); end
  endtask

  task automatic test_fault;
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b0, 32'h13, 32'hDEADBEEF);
    #1;
    total++; if (Fault !== 1'b1 || Done !== 1'b1 || MemWrite !== 1'b0 || Stall !== 1'b0) begin bad++; $display("FAIL fault_ctrl got=%b%b%b%b exp=1100", Fault, Done, MemWrite, Stall); end
    total++; if (ReadData !== 32'h0) begin bad++; $display("FAIL fault_readdata got=%h exp=0", ReadData); end
    total++; if (FaultCount !== 8'd0) begin bad++; $display("FAIL fault_cnt_before got=%0d exp=0", FaultCount); end
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0BADF00D);
    #1;
    total++; if (FaultCount !== 8'd1) begin bad++; $display("FAIL fault_cnt_after got=%0d exp=1", FaultCount); end
    total++; if (mem[4] !== 32'h1122AB44) begin bad++; $display("FAIL fault_nowrite got=%h exp=1122ab44", mem[4]); end
    total++; if (MemWrite !== 1'b1 || Fault !== 1'b0 || Done !== 1'b1) begin bad++; $display("FAIL aligned_store got=%b%b%b exp=101", MemWrite, Fault, Done); end
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++; if (mem[5] !== 32'h0BADF00D || FaultCount !== 8'd1) begin bad++; $display("FAIL aligned_store_mem got=%h/%0d exp=0badf00d/1", mem[5], FaultCount); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [0:1];
    logic [31:0] datas [0:1];
    logic [31:0] exp_wd [0:1];
    addrs[0] = 32'h20; datas[0] = 32'h01; exp_wd[0] = 32'h00000001;
    addrs[1] = 32'h23; datas[1] = 32'h04; exp_wd[1] = 32'h04000001;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      drive(1'b1, 1'b1, 1'b1, addrs[i], datas[i]);
      #1;
      total++; if (Stall !== 1'b1) begin bad++; $display("FAIL b2b%0d_stall1 got=%b exp=1", i, Stall); end
      @(negedge CLK);
      #1;
      total++; if (Stall !== 1'b0 || MemWrite !== 1'b1 || MemWriteData !== exp_wd[i]) begin bad++; $display("FAIL b2b%0d_write got=%b%b/%h exp=01/%h", i, Stall, MemWrite, MemWriteData, exp_wd[i]); end
    end
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++; if (mem[8] !== 32'h04000001) begin bad++; $display("FAIL b2b_final got=%h exp=04000001", mem[8]); end
  endtask

  task automatic test_reset_rmw;
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b1, 32'h31, 32'h55);
    #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL rst_rmw_c1 got=%b exp=1", Stall); end
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    total++; if (MemWrite !== 1'b0 || Done !== 1'b0 || MemAddress !== 32'h0) begin bad++; $display("FAIL rst_rmw_abort got=%b%b/%h exp=00/0", MemWrite, Done, MemAddress); end
    @(negedge CLK);
    RESETn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++; if (mem[12] !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_rmw_mem got=%h exp=cafef00d", mem[12]); end
    total++; if (FaultCount !== 8'd0 || MemWrite !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL rst_rmw_idle got=%0d/%b%b exp=0/00", FaultCount, MemWrite, Done); end
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    #1;
    total++; if (ReadData !== 32'hCAFEF00D || Done !== 1'b1) begin bad++; $display("FAIL rst_rmw_load got=%h exp=cafef00d", ReadData); end
  endtask

  task automatic test_saturation;
    int exp_cnt;
    int bad_rd;
    bad_rd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      drive(1'b1, 1'b0, 1'b0, 32'h01 + 32'(i % 3), 32'h0);
      #1;
      exp_cnt = (i > 255) ? 255 : i;
      total++; if (ReadData !== 32'h0 || Fault !== 1'b1) begin bad++; $display("FAIL sat_rd%0d got=%h/%b exp=0/1", i, ReadData, Fault); end
      total++; if (FaultCount !== 8'(exp_cnt)) begin bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, FaultCount, exp_cnt); end
    end
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++; if (FaultCount !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", FaultCount); end
  endtask

  initial begin
    test_reset;
    test_byte_load;
    test_byte_store;
    test_fault;
    test_back_to_back;
    test_reset_rmw;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_access_unit.md
Name: byte_access_unit

Overview:
- Sits between the datapath's load/store path and the word-only data memory.
- Adds byte loads (LDRB, zero-extended) and byte stores (STRB). Byte stores are done as a two-cycle read-modify-write, because the memory only writes whole words.
- Word accesses pass through in the same cycle.
- Detects misaligned word accesses, suppresses their side effects, and counts them.

Parameters:
- ADDR_WIDTH, 32, byte-address width; the memory word index is bits [ADDR_WIDTH-1:2].
- FAULT_CNT_WIDTH, 8, width of the saturating misaligned-access counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- Req  input  1  datapath access request this cycle.
- MemWriteIn  input  1  1 = store, 0 = load.
- ByteAccess  input  1  1 = byte access, 0 = word access.
- Address  input  ADDR_WIDTH  byte address from the ALU.
- WriteData  input  32  store data; a byte store uses bits [7:0].
- ReadData  output  32  load result to the writeback mux.
- Stall  output  1  freezes the PC and pipeline inputs this cycle.
- Done  output  1  access completes this cycle.
- Fault  output  1  misaligned word access this cycle.
- FaultCount  output  FAULT_CNT_WIDTH  saturating count of faults.
- MemAddress  output  ADDR_WIDTH  address to data memory.
- MemWriteData  output  32  write data to data memory.
- MemWrite  output  1  data memory write enable.
- MemReadData  input  32  combinational read data from data memory.

Behaviour:
- Reset:
  - CLK is the single clock; RESETn is asynchronous and active-low.
  - On reset: state=IDLE, FaultCount=0, latched address/merge registers=0.
  - Outputs while in reset: Stall=0, Done=0, Fault=0, MemWrite=0, ReadData=0, MemAddress=0, MemWriteData=0.
- Endianness is little-endian. Byte lane = Address[1:0]; lane 0 is bits [7:0], lane 3 is bits [31:24].
- States: IDLE, RMW_WR.
- IDLE with Req=0:
  - All control outputs are 0; ReadData=0.
  - MemAddress=Address; MemWriteData=WriteData.
- IDLE, word access, Address[1:0]==0 (0 extra cycles):
  - Load: ReadData=MemReadData, Done=1.
  - Store: MemWrite=1, MemWriteData=WriteData, Done=1.
  - MemAddress=Address.
- IDLE, word access, Address[1:0]!=0:
  - Fault=1, Done=1, MemWrite=0, ReadData=0.
  - FaultCount increments at the clock edge and saturates at all-ones.
- IDLE, byte load (0 extra cycles):
  - ReadData={24'b0, selected lane of MemReadData}, Done=1.
- IDLE, byte store (cycle 1 of 2):
  - MemAddress=Address, MemWrite=0, Stall=1, Done=0.
  - At the edge: latch Address; latch merged word = MemReadData with the selected lane replaced by WriteData[7:0]; go to RMW_WR.
- RMW_WR (cycle 2):
  - MemAddress=latched address, MemWriteData=merged word, MemWrite=1.
  - Stall=0, Done=1; return to IDLE at the next edge.
  - Datapath inputs are ignored in this state. The next access is sampled in IDLE on the following cycle.
- Datapath contract: the datapath holds its inputs while Stall=1. The unit does not depend on this, because it uses latched values in RMW_WR.
- Reset during RMW_WR: the write is aborted (MemWrite forced 0 asynchronously) and the state returns to IDLE. Memory contents are unchanged.
- Fault never stalls. A fault and a byte access cannot coincide, since byte accesses are never misaligned.
- Throughput:
  - 1 access/cycle for word accesses and byte loads.
  - 1 byte store per 2 cycles.
- No X propagation:
  - ReadData is 0 for stores and faults.
  - FaultCount is unchanged on non-fault cycles.

Test Plan:
- Memory word 0x10 = 0x11223344. Byte loads at 0x10/0x11/0x12/0x13 -> ReadData = 0x44 / 0x33 / 0x22 / 0x11, each zero-extended. Done=1, Stall=0 every cycle.
- Byte store WriteData=0xFFFFFFAB to 0x11 -> cycle 1: Stall=1, MemWrite=0; cycle 2: MemWrite=1, MemAddress=0x10, MemWriteData=0x1122AB44, Done=1. A following word load of 0x10 returns 0x1122AB44.
- Word store 0xDEADBEEF to 0x13 -> Fault=1, MemWrite=0, FaultCount 0->1, word 0x10 unchanged. Aligned word store to 0x14 on the next cycle -> MemWrite=1, no fault.
- Back-to-back byte stores to 0x20 lane 0 (0x01) then lane 3 (0x04), word initially 0 -> final word 0x04000001; Stall pattern 1,0,1,0.
- Byte store to 0x30; RESETn pulsed low during RMW_WR -> MemWrite stays 0; word at 0x30 unchanged; state IDLE; FaultCount=0.
- 300 consecutive misaligned word loads -> FaultCount saturates at 255; ReadData=0 throughout.
